// File: rtl/regset_pkg.sv
// Shared constants and state type for the multi-read-port register file.
package regset_pkg;
    localparam int XLEN_DEF     = 32;
    localparam int NREGS_DEF    = 32;
    localparam int NRD_DEF      = 2;
    localparam int ZERO_REG_IDX = 0;

    typedef enum logic [0:0] {
        RS_CLEAR = 1'b0,
        RS_READY = 1'b1
    } regset_state_e;
endpackage

// File: rtl/register_set_mp_if.sv
// Write/read/clear bus of register_set_mp; master drives requests, slave returns read data and status.
interface register_set_mp_if #(
    parameter int XLEN  = regset_pkg::XLEN_DEF,
    parameter int NREGS = regset_pkg::NREGS_DEF,
    parameter int NRD   = regset_pkg::NRD_DEF
);
    localparam int AW = $clog2(NREGS);

    logic                write_en;
    logic [AW-1:0]       WriteAdd;
    logic [XLEN-1:0]     Reg_WriteData;
    logic [NRD*AW-1:0]   ReadAdd;
    logic [NRD*XLEN-1:0] Data;
    logic                clear_req;
    logic                init_done;

    modport master (
        output write_en, WriteAdd, Reg_WriteData, ReadAdd, clear_req,
        input  Data, init_done
    );

    modport slave (
        input  write_en, WriteAdd, Reg_WriteData, ReadAdd, clear_req,
        output Data, init_done
    );
endinterface

// File: rtl/regset_rd_port.sv
// One combinational read port: zero register, clear masking and optional write-first bypass.
// Bypass is compiled in when REGSET_BYPASS_EN is defined.
module regset_rd_port
    import regset_pkg::*;
#(
    parameter int  XLEN  = XLEN_DEF,
    parameter int  NREGS = NREGS_DEF,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic [NREGS*XLEN-1:0] mem_flat_i,
    input  logic                  ready_i,
    input  logic                  wr_hit_en_i,
    input  logic [AW-1:0]         wr_addr_i,
    input  logic [XLEN-1:0]       wr_data_i,
    input  logic [AW-1:0]         rd_addr_i,
    output logic [XLEN-1:0]       rd_data_o
);
`ifdef REGSET_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [XLEN-1:0] stored_s;
    logic            bypass_hit_s;

    assign stored_s     = mem_flat_i[XLEN*int'(rd_addr_i) +: XLEN];
    assign bypass_hit_s = BYPASS && wr_hit_en_i && (wr_addr_i == rd_addr_i);

    // Stale storage is masked while clearing; register 0 always reads zero.
    always_comb begin
        if (!ready_i || (rd_addr_i == AW'(ZERO_REG_IDX))) begin
            rd_data_o = '0;
        end else if (bypass_hit_s) begin
            rd_data_o = wr_data_i;
        end else begin
            rd_data_o = stored_s;
        end
    end
endmodule

// File: rtl/register_set_mp.sv
// Parametrised NRD-read/1-write register file with hardwired-zero r0 and a sequential clear engine.
// Define REGSET_BYPASS_EN for same-cycle write-to-read bypass.
module register_set_mp
    import regset_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = NRD_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    register_set_mp_if.slave  bus
);
    localparam int AW = $clog2(NREGS);
    localparam logic [0:0] ST_CLEAR = RS_CLEAR;
    localparam logic [0:0] ST_READY = RS_READY;

    logic [0:0]            state_q, state_d;
    logic [AW-1:0]         clr_cnt_q, clr_cnt_d;
    logic                  init_done_q;
    logic [XLEN-1:0]       mem_q [NREGS];
    logic [NREGS*XLEN-1:0] mem_flat_s;
    logic [NRD*XLEN-1:0]   rd_data_s;
    logic                  ready_s;
    logic                  wr_hit_en_s;
    logic                  wr_commit_s;

    assign ready_s     = (state_q == ST_READY);
    assign wr_hit_en_s = bus.write_en && (bus.WriteAdd != AW'(ZERO_REG_IDX));
    // A same-cycle clear request wins over the write.
    assign wr_commit_s = ready_s && wr_hit_en_s && !bus.clear_req;

    // Clear engine next-state: walk every index once, then accept traffic.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_cnt_q == AW'(NREGS - 1)) begin
                    state_d   = ST_READY;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + AW'(1);
                end
            end
            ST_READY: begin
                if (bus.clear_req) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = '0;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_cnt_d = '0;
            end
        endcase
    end

    // Control state and the registered init_done status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            clr_cnt_q   <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            init_done_q <= (state_d == ST_READY);
        end
    end

    // Storage is only ever zeroed by the clear engine, never by reset.
    always_ff @(posedge clk) begin
        if (!ready_s) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (wr_commit_s) begin
            mem_q[bus.WriteAdd] <= bus.Reg_WriteData;
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign mem_flat_s[g*XLEN +: XLEN] = mem_q[g];
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        regset_rd_port #(
            .XLEN  (XLEN),
            .NREGS (NREGS)
        ) u_rd_port (
            .mem_flat_i  (mem_flat_s),
            .ready_i     (ready_s),
            .wr_hit_en_i (wr_hit_en_s),
            .wr_addr_i   (bus.WriteAdd),
            .wr_data_i   (bus.Reg_WriteData),
            .rd_addr_i   (bus.ReadAdd[k*AW +: AW]),
            .rd_data_o   (rd_data_s[k*XLEN +: XLEN])
        );
    end

    assign bus.Data      = rd_data_s;
    assign bus.init_done = init_done_q;
endmodule
